// File: rtl/fetch_stage_pkg.sv
// Purpose: shared CPU constants and the IF/ID pipeline register layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic            vld;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{vld: 1'b0, inst: NOP_INST, pc: '0, pc_plus4: '0};

    // Forces a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Purpose: instruction-memory read port between fetch (master) and memory (slave).
// Latency: combinational read; data valid in the cycle the address is presented.
// Backpressure: none; the memory always answers.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_dout;

    modport master (output imem_addr, input imem_dout);
    modport slave  (input imem_addr, output imem_dout);
endinterface

// File: rtl/fetch_stage_pc_register.sv
// Purpose: program counter flop with sequential increment or aligned redirect.
// Latency: new PC visible one edge after the update is requested.
// Backpressure: holds its value when en_i is low and no redirect is present.
module pc_register
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next-PC select: redirect target beats sequential increment; otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
        end else if (en_i) begin
            pc_d = pc_q + PC_INC;  // wraps naturally at 2^32
        end
    end

    // PC state; reset value is aligned so the low bits are never set.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Purpose: instruction fetch; sequences the PC and captures instructions into IF/ID.
// Latency: instruction at pc appears in IF/ID one edge later; redirect costs one bubble.
// Backpressure: stall freezes PC, IF/ID and count; redirect overrides stall.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_stage_if.master         imem,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    output logic [XLEN-1:0]       pc,
    output logic                  if_id_valid,
    output logic [XLEN-1:0]       if_id_inst,
    output logic [XLEN-1:0]       if_id_pc,
    output logic [XLEN-1:0]       if_id_pc_plus4,
    output logic [XLEN-1:0]       fetch_count
);

    logic [XLEN-1:0] pc_w;
    if_id_t          if_id_q;
    if_id_t          if_id_d;
    logic [XLEN-1:0] count_q;
    logic [XLEN-1:0] count_d;
    logic            advance;

    // A fetch is accepted only when neither stalled nor being redirected.
    assign advance = !stall && !redirect_valid;

    pc_register #(
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk           (clk),
        .reset         (reset),
        .en_i          (advance),
        .redirect_i    (redirect_valid),
        .redirect_pc_i (redirect_pc),
        .pc_o          (pc_w)
    );

    // Memory address comes straight from the PC flop, never from an input.
    assign imem.imem_addr = pc_w;

    // IF/ID next state: bubble on redirect (discards wrong-path word), capture on advance.
    always_comb begin
        if_id_d = if_id_q;
        count_d = count_q;
        if (redirect_valid) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (!stall) begin
            if_id_d = '{vld: 1'b1, inst: imem.imem_dout, pc: pc_w, pc_plus4: pc_w + PC_INC};
            count_d = count_q + 32'd1;
        end
    end

    // IF/ID pipeline register and accepted-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_id_q <= IF_ID_BUBBLE;
            count_q <= '0;
        end else begin
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign pc             = pc_w;
    assign if_id_valid    = if_id_q.vld;
    assign if_id_inst     = if_id_q.inst;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus4 = if_id_q.pc_plus4;
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose: directed self-checking bench for fetch_stage with a combinational memory model.
// Latency: inputs change 1ns after a rising edge; outputs checked before the next edge.
// Backpressure: exercises stall, redirect, redirect+stall and mid-stream reset.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic stall_a, redir_a;
    logic [31:0] redir_pc_a;
    logic [31:0] pc_a, inst_a, ifpc_a, ifp4_a, cnt_a;
    logic        vld_a;
    logic [31:0] pc_b, inst_b, ifpc_b, ifp4_b, cnt_b;
    logic        vld_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Memory contents: small table, everything else tagged with its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0011;
            32'h4:   return 32'h0000_0022;
            32'h8:   return 32'h0000_0033;
            32'hC:   return 32'h0000_0044;
            32'h40:  return 32'h0000_00A0;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    fetch_stage_if ifa ();
    fetch_stage_if ifb ();
    assign ifa.imem_dout = mem_word(ifa.imem_addr);
    assign ifb.imem_dout = mem_word(ifb.imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut_a (
        .clk(clk), .reset(reset), .imem(ifa.master),
        .stall(stall_a), .redirect_valid(redir_a), .redirect_pc(redir_pc_a),
        .pc(pc_a), .if_id_valid(vld_a), .if_id_inst(inst_a),
        .if_id_pc(ifpc_a), .if_id_pc_plus4(ifp4_a), .fetch_count(cnt_a)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .reset(reset), .imem(ifb.master),
        .stall(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .pc(pc_b), .if_id_valid(vld_b), .if_id_inst(inst_b),
        .if_id_pc(ifpc_b), .if_id_pc_plus4(ifp4_b), .fetch_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full snapshot of instance A against hand-computed values.
    task automatic chk_a(input string tag, input logic [31:0] e_pc, input logic e_vld,
                         input logic [31:0] e_inst, input logic [31:0] e_ifpc,
                         input logic [31:0] e_ifp4, input logic [31:0] e_cnt);
        chk({tag, ".pc"},    pc_a,   e_pc);
        chk({tag, ".addr"},  ifa.imem_addr, e_pc);
        chk({tag, ".vld"},   {31'b0, vld_a}, {31'b0, e_vld});
        chk({tag, ".inst"},  inst_a, e_inst);
        chk({tag, ".ifpc"},  ifpc_a, e_ifpc);
        chk({tag, ".ifp4"},  ifp4_a, e_ifp4);
        chk({tag, ".cnt"},   cnt_a,  e_cnt);
    endtask

    initial begin
        reset = 1'b1; stall_a = 1'b0; redir_a = 1'b0; redir_pc_a = 32'h0;
        step(); step();
        chk_a("rst", 32'h0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
        chk("rst_b.pc", pc_b, 32'hFFFF_FFFC);
        chk("rst_b.vld", {31'b0, vld_b}, 32'h0);

        // Four free-running fetches.
        reset = 1'b0;
        step();
        chk_a("f0", 32'h4, 1'b1, 32'h11, 32'h0, 32'h4, 32'd1);
        // Wrap-around instance: one free cycle from 0xFFFFFFFC.
        chk("wrap.pc", pc_b, 32'h0);
        chk("wrap.ifpc", ifpc_b, 32'hFFFF_FFFC);
        chk("wrap.ifp4", ifp4_b, 32'h0);
        chk("wrap.inst", inst_b, 32'hC0DE_FFFC);
        chk("wrap.cnt", cnt_b, 32'd1);
        step();
        chk_a("f1", 32'h8, 1'b1, 32'h22, 32'h4, 32'h8, 32'd2);
        step();
        chk_a("f2", 32'hC, 1'b1, 32'h33, 32'h8, 32'hC, 32'd3);
        step();
        chk_a("f3", 32'h10, 1'b1, 32'h44, 32'hC, 32'h10, 32'd4);

        // Restart and stall three cycles at pc=0x8.
        reset = 1'b1; step();
        reset = 1'b0; step(); step();
        chk_a("pre_stall", 32'h8, 1'b1, 32'h22, 32'h4, 32'h8, 32'd2);
        stall_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a($sformatf("stall%0d", i), 32'h8, 1'b1, 32'h22, 32'h4, 32'h8, 32'd2);
        end
        stall_a = 1'b0;
        step();
        chk_a("rel0", 32'hC, 1'b1, 32'h33, 32'h8, 32'hC, 32'd3);
        step();
        chk_a("rel1", 32'h10, 1'b1, 32'h44, 32'hC, 32'h10, 32'd4);

        // Redirect to 0x43 while pc=0x10: one bubble then target.
        redir_a = 1'b1; redir_pc_a = 32'h43;
        step();
        chk_a("redir_bub", 32'h40, 1'b0, 32'h13, 32'h0, 32'h0, 32'd4);
        redir_a = 1'b0;
        step();
        chk_a("redir_tgt", 32'h44, 1'b1, 32'hA0, 32'h40, 32'h44, 32'd5);

        // Redirect and stall together: redirect wins.
        redir_a = 1'b1; stall_a = 1'b1; redir_pc_a = 32'h8;
        step();
        chk_a("rs_bub", 32'h8, 1'b0, 32'h13, 32'h0, 32'h0, 32'd5);
        redir_a = 1'b0; stall_a = 1'b0;
        step();
        chk_a("rs_tgt", 32'hC, 1'b1, 32'h33, 32'h8, 32'hC, 32'd6);

        // Reset with redirect and stall pending: reset wins.
        redir_a = 1'b1; stall_a = 1'b1; redir_pc_a = 32'h100; reset = 1'b1;
        step();
        chk_a("mid_rst", 32'h0, 1'b0, 32'h13, 32'h0, 32'h0, 32'h0);
        reset = 1'b0; redir_a = 1'b0; stall_a = 1'b0;
        step();
        chk_a("post_rst", 32'h4, 1'b1, 32'h11, 32'h0, 32'h4, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the CPU: owns the program counter, drives the address port of `instruction_memory`, and captures the returned instruction into the IF/ID pipeline register for the decode stage. The memory read is combinational, so each fetch completes in the cycle its address is presented; this block supplies sequencing, stalling, redirect on taken branches/jumps, and bubble insertion.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset (word-aligned)
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `imem_addr`  output  32  byte address to instruction memory; equals `pc`
- `imem_dout`  input  32  instruction returned combinationally for `imem_addr`
- `stall`  input  1  hazard unit: hold PC and IF/ID contents
- `redirect_valid`  input  1  EX stage: taken branch/jump this cycle
- `redirect_pc`  input  32  target address; bits [1:0] ignored
- `pc`  output  32  current fetch PC (register)
- `if_id_valid`  output  1  IF/ID holds a real instruction
- `if_id_inst`  output  32  captured instruction; NOP (32'h0000_0013) when invalid
- `if_id_pc`  output  32  PC of captured instruction
- `if_id_pc_plus4`  output  32  `if_id_pc + 4`, modulo 2^32
- `fetch_count`  output  32  number of instructions accepted into IF/ID since reset

## Operation
- All state updates on rising `clk`. Priority: `reset` > `redirect_valid` > `stall` > normal.
- Reset: `pc`=RESET_PC, `if_id_valid`=0, `if_id_inst`=NOP, `if_id_pc`=0, `if_id_pc_plus4`=0, `fetch_count`=0. `imem_addr`=RESET_PC during reset.
- Normal: IF/ID <= {1, `imem_dout`, `pc`, `pc+4`}; `pc` <= `pc+4`; `fetch_count` += 1.
- Stall (no redirect): `pc`, IF/ID, `fetch_count` unchanged.
- Redirect (regardless of `stall`): `pc` <= {`redirect_pc`[31:2], 2'b00}; IF/ID <= bubble (valid 0, inst NOP, pc/pc_plus4 0); `fetch_count` unchanged. The wrong-path instruction currently at `imem_dout` is discarded.
- `pc`[1:0] always 2'b00. PC arithmetic wraps: 32'hFFFF_FFFC + 4 = 0.
- `fetch_count` wraps at 2^32 without flag.
- No decode of instruction content; all-zero words are captured as valid.

## Timing
- `imem_addr` is a direct combinational copy of the `pc` register; no combinational path from any input to `imem_addr`.
- Fetch latency: instruction at address A appears on `if_id_inst` one cycle after `pc`=A, provided no stall/redirect in that cycle.
- Redirect penalty: exactly one bubble; target instruction valid in IF/ID two edges after `redirect_valid` sampled high.
- Stall held N cycles freezes outputs N cycles; release resumes with the instruction at the held `pc`, none skipped or duplicated.
- Reset asserted mid-stream: effective at next edge, overriding pending stall/redirect; first valid IF/ID on first edge after `reset` deasserts, containing mem[RESET_PC>>2].
- `instruction_memory` reloads on the same reset edges; fetch never relies on contents during reset.

## Structure
- Shared CPU package: `RESET_PC` default, `NOP_INST` = 32'h0000_0013, `XLEN` = 32, `PC_INC` = 4.
- One sub-module: `pc_register` (PC flop with reset value, write-enable, next-PC select between pc+4 and aligned redirect target). IF/ID register and counter remain in `fetch_stage`.

## Test plan
- Reset then 4 free cycles, memory words 0x11,0x22,0x33,0x44 at 0x0-0xC -> `if_id_inst` 0x11..0x44 with `if_id_pc` 0,4,8,C; `fetch_count`=4.
- Stall high 3 cycles at `pc`=0x8 -> `pc`, IF/ID, count frozen; after release next capture is mem[0x8], then mem[0xC].
- `redirect_valid` with `redirect_pc`=0x43 while `pc`=0x10 -> `pc`=0x40, next IF/ID valid=0/NOP, following cycle captures mem[0x40] with `if_id_pc`=0x40.
- Redirect and stall same cycle -> redirect wins: `pc`=target, bubble inserted.
- `RESET_PC`=0xFFFF_FFFC, one free cycle -> `if_id_pc_plus4`=0, `pc`=0.
- Reset asserted mid-stream with redirect pending -> all outputs at reset values, `pc`=RESET_PC, count=0.
